mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: sits in the MEM stage between the pipeline and the word-only data memory.
- Converts pipeline load/store requests of word, half or byte width into word-granular memory transactions.
- Sub-word stores become a two-cycle read-modify-write; the pipeline is stalled for that extra cycle.
- Sub-word loads are extracted and sign- or zero-extended; misaligned and out-of-range accesses are flagged and suppressed.

Parameters:
- MEM_WORDS, 4096: words in the data memory; legal byte addresses are 0 .. 4*MEM_WORDS-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  pipeline has a memory request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_width  input  3  000 word; 001 half signed; 010 half unsigned; 011 byte signed; 100 byte unsigned. Stores use 000, 001 and 011 only.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_pc  input  32  PC of the instruction, used for the write trace.
- stall  output  1  pipeline must hold its request stable and not advance.
- resp_rdata  output  32  load result, extended.
- misalign_err  output  1  request rejected.
- mem_adr  output  32  word address to memory; bits [1:0] forced to 0.
- mem_write  output  32  full word to write.
- memw_enable  output  1  memory write strobe.
- mem_pc  output  32  PC forwarded to memory for its write log.
- mem_read  input  32  memory read data, combinational from mem_adr.

Behaviour:
- FSM states: IDLE, RMW_WR.
- Reset values: state IDLE; stall 0; memw_enable 0; misalign_err 0; resp_rdata 0; merge register 0; latched address and PC 0.
- Error condition err = req_valid & (width is half and addr[0] != 0; or width is word and addr[1:0] != 0; or addr >= 4*MEM_WORDS).
  - err is combinational.
  - On err: no write, stall 0, resp_rdata 0, misalign_err 1 for that cycle.
- IDLE, load: mem_adr = {req_addr[31:2], 2'b00}.
  - resp_rdata is produced combinationally the same cycle: select byte addr[1:0] or half addr[1], then sign- or zero-extend per req_width.
  - Zero latency; stall 0.
- IDLE, word store: mem_write = req_wdata and memw_enable = 1 combinationally the same cycle; stall 0.
- IDLE, half or byte store:
  - Read mem_read at the word address.
  - Merge the new lane(s) from req_wdata, then latch the merged word, the word address and req_pc.
  - Assert stall = 1 and go to RMW_WR. memw_enable stays 0 this cycle.
- RMW_WR:
  - Drive the latched address, merged data and PC; memw_enable = 1; stall = 0.
  - Return to IDLE unconditionally; new requests are ignored during this cycle.
  - The pipeline advances on the following edge, so the next request sees the updated memory.
  - Because the pipeline is held, the request inputs are still present during this cycle.
- Byte lane placement is little-endian:
  - byte at addr[1:0]=n occupies bits [8n+7:8n];
  - half at addr[1]=h occupies bits [16h+15:16h].
- mem_pc equals req_pc in IDLE and the latched PC in RMW_WR.
- memw_enable is never asserted while err = 1 and never for two consecutive cycles on one request.
- Reset while in RMW_WR: the pending write is discarded, memw_enable is 0 on the reset cycle, and the state goes to IDLE.
- req_valid = 0 in IDLE: every strobe is 0 and no state change.

Test Plan:
- Memory word 0x10 = 0x8899AABB; load half signed (001) @0x12 -> resp_rdata 0xFFFF8899 same cycle. Load byte unsigned (100) @0x11 -> 0x000000AA.
- Store word 0xDEADBEEF @0x20 -> memw_enable 1 in the same cycle with mem_adr 0x20, mem_write 0xDEADBEEF; stall stays 0.
- Word 0x30 = 0x11223344; store byte 0x55 @0x31 -> cycle 0: stall 1, memw_enable 0; cycle 1: memw_enable 1, mem_write 0x11225544, stall 0. A subsequent load word @0x30 returns 0x11225544.
- Store half 0xCAFE @0x32 onto 0x00000000 -> mem_write 0xCAFE0000 in the RMW_WR cycle.
- Load word @0x21 and store half @0x13 -> misalign_err 1, memw_enable 0, stall 0. Access @0x4000 with MEM_WORDS=4096 -> misalign_err 1.
- Issue a byte store, assert reset in the RMW_WR cycle -> memw_enable 0, memory unchanged, state IDLE, stall 0 on the next cycle.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Pipeline-request and data-memory signal bundle for the MEM-stage access unit.
// slave is the access unit's view; master is the pipeline/memory side that drives it.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_width;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        stall;
  logic [31:0] resp_rdata;
  logic        misalign_err;
  logic [31:0] mem_adr;
  logic [31:0] mem_write;
  logic        memw_enable;
  logic [31:0] mem_pc;
  logic [31:0] mem_read;

  modport master (
    output req_valid, req_we, req_width, req_addr, req_wdata, req_pc, mem_read,
    input  stall, resp_rdata, misalign_err, mem_adr, mem_write, memw_enable, mem_pc
  );

  modport slave (
    input  req_valid, req_we, req_width, req_addr, req_wdata, req_pc, mem_read,
    output stall, resp_rdata, misalign_err, mem_adr, mem_write, memw_enable, mem_pc
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage initiator to a word-only data memory: sub-word load extraction,
// sub-word stores as a two-cycle read-modify-write, and alignment/range rejection.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 4096
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t      state;
  logic [31:0] merge_q;
  logic [31:0] adr_q;
  logic [31:0] pc_q;

  logic        is_half;
  logic        is_byte;
  logic        is_word;
  logic        err;
  logic        sub_store;
  logic [31:0] word_adr;
  logic [4:0]  lane_shift;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic [15:0] load_raw;
  logic [31:0] load_val;

  // Request decode and rejection
  always_comb begin
    is_half   = (bus.req_width == 3'b001) || (bus.req_width == 3'b010);
    is_byte   = (bus.req_width == 3'b011) || (bus.req_width == 3'b100);
    is_word   = !is_half && !is_byte;
    err       = bus.req_valid &&
                ((is_half && bus.req_addr[0]) ||
                 (is_word && (bus.req_addr[1:0] != 2'b00)) ||
                 ({1'b0, bus.req_addr} >= ADDR_LIMIT));
    sub_store = bus.req_valid && bus.req_we && !is_word && !err;
    word_adr  = {bus.req_addr[31:2], 2'b00};
  end

  // Little-endian lane placement shared by load extraction and store merge
  always_comb begin
    lane_shift = is_half ? {bus.req_addr[1], 4'b0000} : {bus.req_addr[1:0], 3'b000};
    lane_mask  = (is_half ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
    merged     = (bus.mem_read & ~lane_mask) | ((bus.req_wdata << lane_shift) & lane_mask);
    load_raw   = 16'(bus.mem_read >> lane_shift);
    case (bus.req_width)
      3'b001:  load_val = {{16{load_raw[15]}}, load_raw};
      3'b010:  load_val = {16'h0000, load_raw};
      3'b011:  load_val = {{24{load_raw[7]}}, load_raw[7:0]};
      3'b100:  load_val = {24'h00_0000, load_raw[7:0]};
      default: load_val = bus.mem_read;
    endcase
  end

  // Bus outputs; reset suppresses every strobe, including a pending RMW write
  always_comb begin
    bus.stall        = 1'b0;
    bus.memw_enable  = 1'b0;
    bus.misalign_err = 1'b0;
    bus.resp_rdata   = 32'h0;
    bus.mem_adr      = word_adr;
    bus.mem_write    = bus.req_wdata;
    bus.mem_pc       = bus.req_pc;
    if (!reset) begin
      if (state == RMW_WR) begin
        bus.mem_adr     = adr_q;
        bus.mem_write   = merge_q;
        bus.mem_pc      = pc_q;
        bus.memw_enable = 1'b1;
      end else if (err) begin
        bus.misalign_err = 1'b1;
      end else if (bus.req_valid) begin
        if (!bus.req_we)  bus.resp_rdata  = load_val;
        else if (is_word) bus.memw_enable = 1'b1;
        else              bus.stall       = 1'b1;
      end
    end
  end

  // State and RMW latches; the RMW_WR cycle ignores the (held) request
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      merge_q <= 32'h0;
      adr_q   <= 32'h0;
      pc_q    <= 32'h0;
    end else if (state == IDLE && sub_store) begin
      state   <= RMW_WR;
      merge_q <= merged;
      adr_q   <= word_adr;
      pc_q    <= bus.req_pc;
    end else begin
      state   <= IDLE;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// traffic against a byte-oriented reference memory model.
module tb_mem_access_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_WORDS(4096)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Word-only data memory: combinational read, write on the strobe
  logic [31:0] mem [0:4095];
  assign bus.mem_read = mem[bus.mem_adr[13:2]];
  always @(posedge clk) if (bus.memw_enable) mem[bus.mem_adr[13:2]] <= bus.mem_write;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference contents of words 0..63 (byte addresses 0x00..0xFF)
  logic [31:0] ref_mem [0:63];

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [2:0] w);
    logic [7:0]  by [4];
    logic [15:0] h;
    logic [7:0]  b;
    for (int i = 0; i < 4; i++) by[i] = word[8*i +: 8];
    h = {by[{a[1], 1'b1}], by[{a[1], 1'b0}]};
    b = by[a[1:0]];
    case (w)
      3'd1:    return (h >= 16'h8000) ? 32'hFFFF_0000 + 32'(h) : 32'(h);
      3'd2:    return 32'(h);
      3'd3:    return (b >= 8'h80) ? 32'hFFFF_FF00 + 32'(b) : 32'(b);
      3'd4:    return 32'(b);
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [31:0] a,
                                            input logic [2:0] w, input logic [31:0] d);
    logic [7:0] by [4];
    for (int i = 0; i < 4; i++) by[i] = word[8*i +: 8];
    if (w == 3'd1 || w == 3'd2) begin
      by[{a[1], 1'b0}] = d[7:0];
      by[{a[1], 1'b1}] = d[15:8];
    end else begin
      by[a[1:0]] = d[7:0];
    end
    return {by[3], by[2], by[1], by[0]};
  endfunction

  function automatic logic ref_err(input logic [31:0] a, input logic [2:0] w);
    if (a >= 32'(4 * 4096)) return 1'b1;
    if (w == 3'd1 || w == 3'd2) return (a % 2) != 0;
    if (w == 3'd3 || w == 3'd4) return 1'b0;
    return (a % 4) != 0;
  endfunction

  task automatic drive(input logic v, input logic we, input logic [2:0] w,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_width = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_pc    = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 3'd3, 32'h31, 32'h55, 32'h40);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({bus.stall, bus.memw_enable, bus.misalign_err, bus.resp_rdata} !== 35'h0) begin
        bad++;
        $display("FAIL reset_outputs flags=%b resp=%h required all zero",
                 {bus.stall, bus.memw_enable, bus.misalign_err}, bus.resp_rdata);
      end
      tick();
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if ({bus.stall, bus.memw_enable, bus.misalign_err} !== 3'b000) begin
      bad++;
      $display("FAIL post_reset_idle flags=%b required 000",
               {bus.stall, bus.memw_enable, bus.misalign_err});
    end
    tick();
  endtask

  task automatic test_load_extract();
    logic [2:0]  ws [4] = '{3'd1, 3'd4, 3'd3, 3'd2};
    logic [31:0] as [4] = '{32'h12, 32'h11, 32'h10, 32'h10};
    logic [31:0] es [4] = '{32'hFFFF_8899, 32'h0000_00AA, 32'hFFFF_FFBB, 32'h0000_AABB};
    drive(1'b1, 1'b1, 3'd0, 32'h10, 32'h8899_AABB, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, ws[i], as[i], 32'h0, 32'h0);
      @(negedge clk);
      total++;
      if ({bus.stall, bus.memw_enable, bus.misalign_err, bus.resp_rdata} !== {3'b000, es[i]}) begin
        bad++;
        $display("FAIL load_extract[%0d] flags=%b resp=%h required flags=000 resp=%h", i,
                 {bus.stall, bus.memw_enable, bus.misalign_err}, bus.resp_rdata, es[i]);
      end
      tick();
    end
  endtask

  task automatic test_word_store();
    drive(1'b1, 1'b1, 3'd0, 32'h20, 32'hDEAD_BEEF, 32'h100);
    @(negedge clk);
    total++;
    if ({bus.stall, bus.memw_enable, bus.misalign_err, bus.mem_adr, bus.mem_write, bus.mem_pc}
        !== {3'b010, 32'h20, 32'hDEAD_BEEF, 32'h100}) begin
      bad++;
      $display("FAIL word_store flags=%b adr=%h data=%h pc=%h required 010 20 deadbeef 100",
               {bus.stall, bus.memw_enable, bus.misalign_err}, bus.mem_adr, bus.mem_write, bus.mem_pc);
    end
    tick();
    drive(1'b1, 1'b0, 3'd0, 32'h20, 32'h0, 32'h104);
    @(negedge clk);
    total++;
    if (bus.resp_rdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL word_readback resp=%h required deadbeef", bus.resp_rdata);
    end
    tick();
  endtask

  task automatic test_sub_rmw(input logic [2:0] w, input logic [31:0] base, input logic [31:0] init,
                              input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    drive(1'b1, 1'b1, 3'd0, base, init, 32'h0);
    tick();
    drive(1'b1, 1'b1, w, a, d, 32'h200);
    @(negedge clk);
    total++;
    if ({bus.stall, bus.memw_enable, bus.misalign_err} !== 3'b100) begin
      bad++;
      $display("FAIL rmw_read_cycle a=%h flags=%b required 100", a,
               {bus.stall, bus.memw_enable, bus.misalign_err});
    end
    tick();
    @(negedge clk);
    total++;
    if ({bus.stall, bus.memw_enable, bus.misalign_err, bus.mem_adr, bus.mem_write, bus.mem_pc}
        !== {3'b010, base, exp, 32'h200}) begin
      bad++;
      $display("FAIL rmw_write_cycle flags=%b adr=%h data=%h pc=%h required 010 %h %h 200",
               {bus.stall, bus.memw_enable, bus.misalign_err}, bus.mem_adr, bus.mem_write,
               bus.mem_pc, base, exp);
    end
    tick();
    drive(1'b1, 1'b0, 3'd0, base, 32'h0, 32'h204);
    @(negedge clk);
    total++;
    if ({bus.memw_enable, bus.resp_rdata} !== {1'b0, exp}) begin
      bad++;
      $display("FAIL rmw_readback memw=%b resp=%h required 0 %h", bus.memw_enable, bus.resp_rdata, exp);
    end
    tick();
  endtask

  task automatic test_errors();
    logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  ws  [4] = '{3'd0, 3'd1, 3'd0, 3'd3};
    logic [31:0] as  [4] = '{32'h21, 32'h13, 32'h4000, 32'h4001};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, wes[i], ws[i], as[i], 32'hFFFF_FFFF, 32'h300);
      @(negedge clk);
      total++;
      if ({bus.stall, bus.memw_enable, bus.misalign_err, bus.resp_rdata} !== {3'b001, 32'h0}) begin
        bad++;
        $display("FAIL error_case[%0d] flags=%b resp=%h required 001 0", i,
                 {bus.stall, bus.memw_enable, bus.misalign_err}, bus.resp_rdata);
      end
      tick();
    end
    drive(1'b0, 1'b1, 3'd1, 32'h13, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if ({bus.stall, bus.memw_enable, bus.misalign_err} !== 3'b000) begin
      bad++;
      $display("FAIL error_no_followup flags=%b required 000",
               {bus.stall, bus.memw_enable, bus.misalign_err});
    end
    tick();
  endtask

  task automatic test_reset_in_rmw();
    drive(1'b1, 1'b1, 3'd0, 32'h50, 32'h0102_0304, 32'h0);
    tick();
    drive(1'b1, 1'b1, 3'd3, 32'h50, 32'hEE, 32'h400);
    @(negedge clk);
    total++;
    if (bus.stall !== 1'b1) begin
      bad++;
      $display("FAIL rst_rmw_stall stall=%b required 1", bus.stall);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.memw_enable !== 1'b0) begin
      bad++;
      $display("FAIL rst_rmw_write memw=%b required 0", bus.memw_enable);
    end
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'h50, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if ({bus.stall, bus.memw_enable, bus.misalign_err} !== 3'b000) begin
      bad++;
      $display("FAIL rst_rmw_idle flags=%b required 000",
               {bus.stall, bus.memw_enable, bus.misalign_err});
    end
    tick();
    drive(1'b1, 1'b0, 3'd0, 32'h50, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (bus.resp_rdata !== 32'h0102_0304) begin
      bad++;
      $display("FAIL rst_rmw_mem resp=%h required 01020304", bus.resp_rdata);
    end
    tick();
  endtask

  task automatic test_random();
    logic        v, we, e;
    logic [2:0]  w;
    logic [31:0] a, d, pc, exp;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      drive(1'b1, 1'b1, 3'd0, 32'(i * 4), d, 32'h0);
      @(negedge clk);
      total++;
      if ({bus.memw_enable, bus.mem_adr, bus.mem_write} !== {1'b1, 32'(i * 4), d}) begin
        bad++;
        $display("FAIL preload[%0d] memw=%b adr=%h data=%h required 1 %h %h", i,
                 bus.memw_enable, bus.mem_adr, bus.mem_write, 32'(i * 4), d);
      end
      ref_mem[i] = d;
      tick();
    end
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 7) != 0);
      we = 1'($urandom_range(0, 1));
      if (we) begin
        case ($urandom_range(0, 2))
          0:       w = 3'd0;
          1:       w = 3'd1;
          default: w = 3'd3;
        endcase
      end else begin
        w = 3'($urandom_range(0, 4));
      end
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (w == 3'd0) a = a & ~32'd3;
        else if (w == 3'd1 || w == 3'd2) a = a & ~32'd1;
      end
      if ($urandom_range(0, 15) == 0) a = 32'h4000 + 32'($urandom_range(0, 1023));
      d  = $urandom;
      pc = $urandom & ~32'd3;
      e  = v && ref_err(a, w);
      drive(v, we, w, a, d, pc);
      @(negedge clk);
      total++;
      if (!v) begin
        if ({bus.stall, bus.memw_enable, bus.misalign_err, bus.resp_rdata} !== 35'h0) begin
          bad++;
          $display("FAIL rnd_idle[%0d] flags=%b resp=%h required 000 0", n,
                   {bus.stall, bus.memw_enable, bus.misalign_err}, bus.resp_rdata);
        end
        tick();
      end else if (e) begin
        if ({bus.stall, bus.memw_enable, bus.misalign_err, bus.resp_rdata} !== {3'b001, 32'h0}) begin
          bad++;
          $display("FAIL rnd_err[%0d] a=%h w=%0d flags=%b resp=%h required 001 0", n, a, w,
                   {bus.stall, bus.memw_enable, bus.misalign_err}, bus.resp_rdata);
        end
        tick();
      end else if (!we) begin
        exp = ref_load(ref_mem[a / 4], a, w);
        if ({bus.stall, bus.memw_enable, bus.misalign_err, bus.resp_rdata} !== {3'b000, exp}) begin
          bad++;
          $display("FAIL rnd_load[%0d] a=%h w=%0d flags=%b resp=%h required 000 %h", n, a, w,
                   {bus.stall, bus.memw_enable, bus.misalign_err}, bus.resp_rdata, exp);
        end
        tick();
      end else if (w == 3'd0) begin
        if ({bus.stall, bus.memw_enable, bus.misalign_err, bus.mem_adr, bus.mem_write, bus.mem_pc}
            !== {3'b010, a, d, pc}) begin
          bad++;
          $display("FAIL rnd_wstore[%0d] flags=%b adr=%h data=%h pc=%h required 010 %h %h %h", n,
                   {bus.stall, bus.memw_enable, bus.misalign_err}, bus.mem_adr, bus.mem_write,
                   bus.mem_pc, a, d, pc);
        end
        ref_mem[a / 4] = d;
        tick();
      end else begin
        exp = ref_merge(ref_mem[a / 4], a, w, d);
        if ({bus.stall, bus.memw_enable, bus.misalign_err} !== 3'b100) begin
          bad++;
          $display("FAIL rnd_rmw_rd[%0d] flags=%b required 100", n,
                   {bus.stall, bus.memw_enable, bus.misalign_err});
        end
        tick();
        @(negedge clk);
        total++;
        if ({bus.stall, bus.memw_enable, bus.misalign_err, bus.mem_adr, bus.mem_write, bus.mem_pc}
            !== {3'b010, a & ~32'd3, exp, pc}) begin
          bad++;
          $display("FAIL rnd_rmw_wr[%0d] flags=%b adr=%h data=%h pc=%h required 010 %h %h %h", n,
                   {bus.stall, bus.memw_enable, bus.misalign_err}, bus.mem_adr, bus.mem_write,
                   bus.mem_pc, a & ~32'd3, exp, pc);
        end
        ref_mem[a / 4] = exp;
        tick();
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
    tick();
    test_reset();
    test_load_extract();
    test_word_store();
    test_sub_rmw(3'd3, 32'h30, 32'h1122_3344, 32'h31, 32'h0000_0055, 32'h1122_5544);
    test_sub_rmw(3'd1, 32'h40, 32'h0000_0000, 32'h42, 32'h1234_CAFE, 32'hCAFE_0000);
    test_errors();
    test_reset_in_rmw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
